fifo_pkt_reader: RTL and testbench

Downstream consumer of the per-port synchronous FIFO (FWFT mode) in the multi-port cache datapath. It pops length-prefixed packets word by word from the FIFO, strips and decodes the header word, and presents the payload on a registered valid/ready stream with sop/eop framing and destination port tag. It feeds the port arbiter / cache write stage.

---
 rtl/mpc_pkg.sv | 19 +
 rtl/fifo_pkt_reader_if.sv | 29 ++
 rtl/pkt_out_reg.sv | 74 +++++++
 rtl/fifo_pkt_reader.sv | 126 ++++++++++++
 tb/tb_fifo_pkt_reader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mpc_pkg.sv
// Shared definitions for the multi-port cache datapath: header field layout
// and the packet reader state encoding.
package mpc_pkg;

  localparam int LEN_W_DEF    = 4;
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_DEST_LSB = HDR_LEN_LSB + LEN_W_DEF;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } rd_state_e;

  // Destination field sits directly above the length field.
  function automatic int hdr_dest_lsb(input int len_w);
    return HDR_LEN_LSB + len_w;
  endfunction

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// FWFT FIFO read side plus the framed payload stream of the packet reader.
interface fifo_pkt_reader_if
  import mpc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_W     = 2
) ();

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sop;
  logic                  m_eop;
  logic [PORT_W-1:0]     m_dest;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, m_sop, m_eop, m_dest
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_sop, m_eop, m_dest
  );

endinterface

// File: rtl/pkt_out_reg.sv
// Single-entry valid/ready output register for {data, sop, eop, dest};
// can_load_o tells the producer when a new word may be written.
module pkt_out_reg
  import mpc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic [PORT_W-1:0]     dest_i,
  input  logic                  ready_i,
  output logic                  can_load_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic [PORT_W-1:0]     dest_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [PORT_W-1:0]     dest_q, dest_d;

  assign can_load_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    dest_d  = dest_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sop_d   = sop_i;
      eop_d   = eop_i;
      dest_d  = dest_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      dest_q  <= {PORT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      dest_q  <= dest_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign dest_o  = dest_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed packets from an FWFT FIFO, drops the header word and
// streams the payload with sop/eop framing and the decoded destination port.
module fifo_pkt_reader
  import mpc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 4,
  parameter int PORT_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_pkt_reader_if.master  bus,
  output logic               err_len
);

  localparam int DEST_LSB = hdr_dest_lsb(LEN_W);

  rd_state_e         state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PORT_W-1:0] dest_q, dest_d;
  logic              first_q, first_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  hdr_len_s;
  logic [PORT_W-1:0] hdr_dest_s;
  logic              last_s;
  logic              can_load_s;
  logic              pop_s;
  logic              rd_en_s;

  assign hdr_len_s  = bus.fifo_dout[HDR_LEN_LSB +: LEN_W];
  assign hdr_dest_s = bus.fifo_dout[DEST_LSB +: PORT_W];
  assign last_s     = (cnt_q == (len_q - LEN_W'(1)));

  // No pops while reset is held, so nothing is lost from the FIFO.
  assign bus.fifo_rd_en = rd_en_s & rst_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dest_d  = dest_q;
    first_d = first_q;
    err_d   = 1'b0;
    rd_en_s = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          rd_en_s = 1'b1;
          len_d   = hdr_len_s;
          dest_d  = hdr_dest_s;
          if (hdr_len_s != {LEN_W{1'b0}}) begin
            state_d = PAYLOAD;
            cnt_d   = {LEN_W{1'b0}};
            first_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      PAYLOAD: begin
        if (!bus.fifo_empty && can_load_s) begin
          rd_en_s = 1'b1;
          pop_s   = 1'b1;
          first_d = 1'b0;
          cnt_d   = cnt_q + LEN_W'(1);
          if (last_s) begin
            state_d = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {LEN_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      dest_q  <= {PORT_W{1'b0}};
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dest_q  <= dest_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign err_len = err_q;

  pkt_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PORT_W     (PORT_W)
  ) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pop_s),
    .data_i     (bus.fifo_dout),
    .sop_i      (first_q),
    .eop_i      (last_s),
    .dest_i     (dest_q),
    .ready_i    (bus.m_ready),
    .can_load_o (can_load_s),
    .valid_o    (bus.m_valid),
    .data_o     (bus.m_data),
    .sop_o      (bus.m_sop),
    .eop_o      (bus.m_eop),
    .dest_o     (bus.m_dest)
  );

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: per-cycle vector table for the basic
// and stalled packet, then hand-written multi-cycle sequences.
module tb_fifo_pkt_reader;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_len;

  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.DATA_WIDTH(DW), .PORT_W(PW)) bus ();

  fifo_pkt_reader #(.DATA_WIDTH(DW), .LEN_W(LW), .PORT_W(PW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .err_len (err_len)
  );

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] dest;
  } word_t;

  typedef struct {
    bit         restart;
    logic       ready;
    logic       rd;
    logic       vld;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] dest;
  } vec_t;

  logic [7:0] fifo_q[$];
  word_t      got_q[$];
  word_t      exp_q[$];
  vec_t       vecs[15];
  int         checks = 0;
  int         errors = 0;
  int         pops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: record handshakes, pop the FIFO model if the DUT asked.
  task automatic tick();
    logic  rd_s;
    word_t w;
    rd_s = bus.fifo_rd_en;
    chk("rd_en_while_empty", {31'd0, rd_s & bus.fifo_empty}, 32'd0);
    if (bus.m_valid && bus.m_ready) begin
      w.data = bus.m_data;
      w.sop  = bus.m_sop;
      w.eop  = bus.m_eop;
      w.dest = bus.m_dest;
      got_q.push_back(w);
    end
    @(posedge clk);
    if (rd_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    drive_fifo();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    drive_fifo();
    #1;
    tick();
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    #1;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic s, input logic e, input logic [1:0] p);
    word_t w;
    w.data = d;
    w.sop  = s;
    w.eop  = e;
    w.dest = p;
    exp_q.push_back(w);
  endtask

  task automatic check_words(input string name);
    chk($sformatf("%s_count", name), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_word%0d", name, i),
          {20'd0, got_q[i].data, got_q[i].sop, got_q[i].eop, got_q[i].dest},
          {20'd0, exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].dest});
    end
  endtask

  initial begin
    bus.m_ready = 1'b1;
    drive_fifo();

    // Rows 0-5: header 0x23 + A1..A3 with ready high; rows 6-14: A2 stalled 3 cycles.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 2'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 2'd2};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};

    do_reset();
    chk("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("reset_m_data", {24'd0, bus.m_data}, 32'd0);
    chk("reset_err_len", {31'd0, err_len}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].restart) begin
        do_reset();
        fifo_q = '{8'h23, 8'hA1, 8'hA2, 8'hA3};
        drive_fifo();
      end
      bus.m_ready = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_rd_en", i), {31'd0, bus.fifo_rd_en}, {31'd0, vecs[i].rd});
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.m_valid}, {31'd0, vecs[i].vld});
      if (vecs[i].vld) begin
        chk($sformatf("vec%0d_data", i), {24'd0, bus.m_data}, {24'd0, vecs[i].data});
        chk($sformatf("vec%0d_sop", i), {31'd0, bus.m_sop}, {31'd0, vecs[i].sop});
        chk($sformatf("vec%0d_eop", i), {31'd0, bus.m_eop}, {31'd0, vecs[i].eop});
        chk($sformatf("vec%0d_dest", i), {30'd0, bus.m_dest}, {30'd0, vecs[i].dest});
      end
      tick();
    end

    // len=0 header is dropped with one err_len pulse; next packet is single-word.
    do_reset();
    bus.m_ready = 1'b1;
    fifo_q = '{8'h10, 8'h01, 8'h5A};
    drive_fifo();
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("err_len_cyc%0d", k), {31'd0, err_len}, (k == 1) ? 32'd1 : 32'd0);
      tick();
    end
    expect_word(8'h5A, 1'b1, 1'b1, 2'd0);
    check_words("len0");

    // Underrun after word 2 of a len=4 packet.
    do_reset();
    fifo_q = '{8'h14, 8'hB1, 8'hB2};
    drive_fifo();
    #1;
    for (int k = 0; k < 3; k++) tick();
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("gap%0d_rd_en", g), {31'd0, bus.fifo_rd_en}, 32'd0);
      tick();
    end
    fifo_q.push_back(8'hB3);
    fifo_q.push_back(8'hB4);
    drive_fifo();
    #1;
    for (int k = 0; k < 6; k++) tick();
    expect_word(8'hB1, 1'b1, 1'b0, 2'd1);
    expect_word(8'hB2, 1'b0, 1'b0, 2'd1);
    expect_word(8'hB3, 1'b0, 1'b0, 2'd1);
    expect_word(8'hB4, 1'b0, 1'b1, 2'd1);
    check_words("underrun");

    // Reset mid-packet with A1 still pending; the next word is a fresh header.
    do_reset();
    bus.m_ready = 1'b0;
    fifo_q = '{8'h23, 8'hA1};
    drive_fifo();
    #1;
    tick();
    tick();
    chk("midrst_pre_valid", {31'd0, bus.m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("midrst_data", {24'd0, bus.m_data}, 32'd0);
    chk("midrst_sop_eop", {30'd0, bus.m_sop, bus.m_eop}, 32'd0);
    chk("midrst_dest", {30'd0, bus.m_dest}, 32'd0);
    chk("midrst_err", {31'd0, err_len}, 32'd0);
    chk("midrst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    bus.m_ready = 1'b1;
    fifo_q.push_back(8'h31);
    fifo_q.push_back(8'h66);
    drive_fifo();
    #1;
    for (int k = 0; k < 5; k++) tick();
    expect_word(8'h66, 1'b1, 1'b1, 2'd3);
    check_words("midrst");

    // Two back-to-back len=15 packets at full rate.
    do_reset();
    bus.m_ready = 1'b1;
    fifo_q.push_back(8'h1F);
    for (int i = 0; i < 15; i++) begin
      fifo_q.push_back(8'h10 + 8'(i));
      expect_word(8'h10 + 8'(i), (i == 0), (i == 14), 2'd1);
    end
    fifo_q.push_back(8'h2F);
    for (int i = 0; i < 15; i++) begin
      fifo_q.push_back(8'h80 + 8'(i));
      expect_word(8'h80 + 8'(i), (i == 0), (i == 14), 2'd2);
    end
    drive_fifo();
    #1;
    pops = 0;
    for (int k = 0; k < 32; k++) begin
      if (bus.fifo_rd_en) pops++;
      tick();
    end
    chk("b2b_pops_in_32", pops, 32'd32);
    tick();
    check_words("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
